// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, FSM encoding and dither LFSR constants for cordic_phase_gen
package cordic_pkg;

  localparam int PHASE_W            = 32;
  localparam int CORDIC_LAT_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE_C = 2'd0;
  localparam logic [1:0] ST_RUN_C  = 2'd1;
  localparam logic [1:0] ST_PEND_C = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_C,
    ST_RUN  = ST_RUN_C,
    ST_PEND = ST_PEND_C
  } state_e;

  // x^32 + x^22 + x^2 + x + 1 as a left-shifting Fibonacci feedback mask
  localparam logic [PHASE_W-1:0] LFSR_SEED = 32'hACE1_2468;
  localparam logic [PHASE_W-1:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/cordic_lfsr32.sv
// rtl/cordic_lfsr32.sv - free-running 32-bit maximal-length LFSR used as the angle dither source
module cordic_lfsr32
  import cordic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [PHASE_W-1:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[PHASE_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// rtl/cordic_phase_gen.sv - phase accumulator and config sequencer feeding a CORDIC rotator
// Optional angle dither is enabled by defining CORDIC_PHASE_GEN_DITHER_EN.
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CORDIC_LAT = CORDIC_LAT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      sync,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PHASE_W-1:0]        cfg_freq,
  input  logic [PHASE_W-1:0]        cfg_phase,
  input  logic [WIDTH-1:0]          cfg_amp,
  output logic signed [PHASE_W-1:0] angle,
  output logic signed [WIDTH-1:0]   x_start,
  output logic signed [WIDTH-1:0]   y_start,
  output logic                      out_valid
);

  state_e               state, state_nx;
  logic [PHASE_W-1:0]   acc, freq, phase, sh_freq, sh_phase;
  logic [WIDTH-1:0]     amp, sh_amp;
  logic [PHASE_W:0]     acc_sum;
  logic                 wrap, cfg_acc, load_cfg, load_sh, stage;
  logic [CORDIC_LAT:0]  vld_sr;
  logic [PHASE_W-1:0]   dither;

`ifdef CORDIC_PHASE_GEN_DITHER_EN
  logic [PHASE_W-1:0] lfsr;

  cordic_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  // lfsr[7:0] - 128: flipping the MSB turns the offset byte into two's complement
  assign dither = {{(PHASE_W-8){~lfsr[7]}}, ~lfsr[7], lfsr[6:0]};
`else
  assign dither = '0;
`endif

  assign cfg_ready = (state != ST_PEND);
  assign cfg_acc   = cfg_valid & cfg_ready;
  assign acc_sum   = {1'b0, acc} + {1'b0, freq};
  assign wrap      = acc_sum[PHASE_W];
  assign y_start   = '0;
  assign out_valid = vld_sr[CORDIC_LAT];

  always_comb begin
    load_cfg = 1'b0;
    load_sh  = 1'b0;
    stage    = 1'b0;
    state_nx = state;
    if (sync) begin
      load_cfg = cfg_acc;
      load_sh  = (state == ST_PEND);
      state_nx = en ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          load_cfg = cfg_acc;
          state_nx = en ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (cfg_acc && en) begin
            stage    = 1'b1;
            state_nx = ST_PEND;
          end else begin
            // with en low the accumulator is frozen, so a direct load keeps phase
            load_cfg = cfg_acc;
            state_nx = en ? ST_RUN : ST_IDLE;
          end
        end
        ST_PEND: begin
          if (!en) begin
            load_sh  = 1'b1;
            state_nx = ST_IDLE;
          end else if (wrap) begin
            load_sh  = 1'b1;
            state_nx = ST_RUN;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      freq     <= '0;
      phase    <= '0;
      amp      <= '0;
      sh_freq  <= '0;
      sh_phase <= '0;
      sh_amp   <= '0;
      angle    <= '0;
      x_start  <= '0;
    end else begin
      state <= state_nx;
      if (sync) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc_sum[PHASE_W-1:0];
      end
      if (load_cfg) begin
        freq  <= cfg_freq;
        phase <= cfg_phase;
        amp   <= cfg_amp;
      end else if (load_sh) begin
        freq  <= sh_freq;
        phase <= sh_phase;
        amp   <= sh_amp;
      end
      if (stage) begin
        sh_freq  <= cfg_freq;
        sh_phase <= cfg_phase;
        sh_amp   <= cfg_amp;
      end
      angle   <= acc + phase + dither;
      x_start <= amp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= en;
      for (int i = 1; i <= CORDIC_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb/tb_cordic_phase_gen.sv - directed vector bench for cordic_phase_gen
// Define CORDIC_PHASE_GEN_DITHER_EN to exercise the dither statistics instead of exact angles.
module tb_cordic_phase_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en, sync, cfg_valid;
  logic               cfg_ready;
  logic [31:0]        cfg_freq, cfg_phase;
  logic [15:0]        cfg_amp;
  logic signed [31:0] angle;
  logic signed [15:0] x_start, y_start;
  logic               out_valid;

  int n_checks = 0;
  int n_err    = 0;

  cordic_phase_gen #(.WIDTH(16), .CORDIC_LAT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_freq  (cfg_freq),
    .cfg_phase (cfg_phase),
    .cfg_amp   (cfg_amp),
    .angle     (angle),
    .x_start   (x_start),
    .y_start   (y_start),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        sync;
    logic        cv;
    logic [31:0] freq;
    logic [31:0] phase;
    logic [15:0] amp;
    logic [31:0] exp_angle;
    logic [15:0] exp_x;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_freq  = '0;
    cfg_phase = '0;
    cfg_amp   = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    en        = 1'b0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_freq  = '0;
    cfg_phase = '0;
    cfg_amp   = '0;
    step();
    check("reset angle", angle, 32'h0);
    check("reset x_start", {16'h0, x_start}, 32'h0);
    check("reset y_start", {16'h0, y_start}, 32'h0);
    check("reset cfg_ready", {31'h0, cfg_ready}, 32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    rst_n = 1'b1;

`ifdef CORDIC_PHASE_GEN_DITHER_EN
    begin
      longint sum = 0;
      int     bad = 0;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 65536; i++) begin
        step();
        if (angle < -128 || angle > 127) bad++;
        sum += longint'(angle);
      end
      check("dither range violations", bad, 0);
      check("dither mean within 2", {31'h0, (sum <= 131072 && sum >= -131072)}, 32'h1);
    end
`else
    // en, sync, cv, freq, phase, amp, exp_angle, exp_x, exp_rdy
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h2000_0000, 32'h0, 16'h4000, 32'h0000_0000, 16'h0000, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h0000_0000, 16'h4000, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h2000_0000, 16'h4000, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h4000_0000, 16'h4000, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h6000_0000, 16'h4000, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h8000_0000, 16'h4000, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h4000_0000, 32'h0, 16'h4000, 32'h8000_0000, 16'h4000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h0000_0000, 16'h4000, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h1000_0000, 32'h0, 16'h2000, 32'h4000_0000, 16'h4000, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0, 16'h7FFF, 32'h8000_0000, 16'h4000, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'hC000_0000, 16'h4000, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h0000_0000, 16'h2000, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h1000_0000, 16'h2000, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 16'h0,    32'h2000_0000, 16'h2000, 1'b1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      en        = tbl[i].en;
      sync      = tbl[i].sync;
      cfg_valid = tbl[i].cv;
      cfg_freq  = tbl[i].freq;
      cfg_phase = tbl[i].phase;
      cfg_amp   = tbl[i].amp;
      step();
      check($sformatf("row%0d angle", i), angle, tbl[i].exp_angle);
      check($sformatf("row%0d x_start", i), {16'h0, x_start}, {16'h0, tbl[i].exp_x});
      check($sformatf("row%0d cfg_ready", i), {31'h0, cfg_ready}, {31'h0, tbl[i].exp_rdy});
    end
    check("y_start constant", {16'h0, y_start}, 32'h0);
    cfg_valid = 1'b0;
    sync      = 1'b0;

    // sync with acc=0x12345678, phase=0x08000000
    do_reset();
    cfg_valid = 1'b1; cfg_freq = 32'h1234_5678; cfg_phase = 32'h0800_0000; cfg_amp = 16'h0;
    step();
    cfg_valid = 1'b0; en = 1'b1;
    step();
    en = 1'b0; sync = 1'b1;
    step();
    check("sync pre angle", angle, 32'h1A34_5678);
    sync = 1'b0;
    step();
    check("sync post angle", angle, 32'h0800_0000);

    // sync coinciding with config accept while running
    do_reset();
    cfg_valid = 1'b1; cfg_freq = 32'h0010_0000; cfg_phase = 32'h0; cfg_amp = 16'h0;
    step();
    cfg_valid = 1'b0; en = 1'b1;
    repeat (3) step();
    sync = 1'b1; cfg_valid = 1'b1; cfg_freq = 32'h0100_0000;
    check("sync+cfg ready before", {31'h0, cfg_ready}, 32'h1);
    step();
    sync = 1'b0; cfg_valid = 1'b0;
    check("sync+cfg angle", angle, 32'h0030_0000);
    check("sync+cfg not pending", {31'h0, cfg_ready}, 32'h1);
    step();
    check("sync+cfg acc zero", angle, 32'h0);
    step();
    check("sync+cfg new freq", angle, 32'h0100_0000);

    // reset while a staged config is pending
    do_reset();
    cfg_valid = 1'b1; cfg_freq = 32'h4000_0000; cfg_phase = 32'h100; cfg_amp = 16'h1234;
    step();
    cfg_valid = 1'b0; en = 1'b1;
    repeat (2) step();
    cfg_valid = 1'b1; cfg_freq = 32'h1; cfg_amp = 16'h7FFF;
    step();
    cfg_valid = 1'b0;
    check("pend cfg_ready", {31'h0, cfg_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midpend reset angle", angle, 32'h0);
    check("midpend reset x_start", {16'h0, x_start}, 32'h0);
    check("midpend reset cfg_ready", {31'h0, cfg_ready}, 32'h1);
    check("midpend reset out_valid", {31'h0, out_valid}, 32'h0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("staged freq discarded angle", angle, 32'h0);
    check("staged amp discarded x_start", {16'h0, x_start}, 32'h0);

    // out_valid latency on rise and fall of en
    do_reset();
    en = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("out_valid rise latency", n, 17);
    repeat (3) step();
    en = 1'b0;
    n = 0;
    while (out_valid && n < 40) begin
      step();
      n++;
    end
    check("out_valid fall latency", n, 17);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
